// File: rtl/seg_display_scanner_pkg.sv
// Shared constants and the hex-to-segment decoder for the display scanner.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg_display_scanner_pkg;

    localparam int unsigned NUM_DIGITS_DEF = 4;
    localparam logic [6:0]  SEG_BLANK      = 7'h7F;
    localparam logic        AN_OFF         = 1'b1;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] i_hex);
        logic [6:0] w_seg;
        case (i_hex)
            4'h0:    w_seg = 7'h40;
            4'h1:    w_seg = 7'h79;
            4'h2:    w_seg = 7'h24;
            4'h3:    w_seg = 7'h30;
            4'h4:    w_seg = 7'h19;
            4'h5:    w_seg = 7'h12;
            4'h6:    w_seg = 7'h02;
            4'h7:    w_seg = 7'h78;
            4'h8:    w_seg = 7'h00;
            4'h9:    w_seg = 7'h10;
            4'hA:    w_seg = 7'h08;
            4'hB:    w_seg = 7'h03;
            4'hC:    w_seg = 7'h46;
            4'hD:    w_seg = 7'h21;
            4'hE:    w_seg = 7'h06;
            default: w_seg = 7'h0E;
        endcase
        return w_seg;
    endfunction

endpackage

// File: rtl/seg_display_scanner_if.sv
// Frame-data inputs and display outputs of the scanner, grouped as one bundle.
// master drives frame data and divided clocks; slave is the scanner.
interface seg_display_scanner_if
    import seg_display_scanner_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF
);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    scan_clk;
    logic                    blink_clk;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp_out;
    logic [IDX_W-1:0]        digit_idx;

    modport master (
        output scan_clk, blink_clk, load, digits, dp_in, blank_mask, blink_mask,
        input  an, seg, dp_out, digit_idx
    );

    modport slave (
        input  scan_clk, blink_clk, load, digits, dp_in, blank_mask, blink_mask,
        output an, seg, dp_out, digit_idx
    );

endinterface

// File: rtl/seg_display_scanner_sync_edge.sv
// Multi-flop synchroniser for a slow asynchronous level, with a registered
// one-cycle pulse on each synchronised 0->1 transition.
module seg_display_scanner_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level_d;
    logic                   r_rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync    <= '0;
            r_level_d <= 1'b0;
            r_rise    <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_level_d <= r_sync[SYNC_STAGES-1];
            r_rise    <= r_sync[SYNC_STAGES-1] & ~r_level_d;
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_rise;

endmodule

// File: rtl/seg_display_scanner.sv
// Scans a multiplexed common-anode seven-segment display, stepping on each
// synchronised scan_clk rise; frame data is double-buffered and committed at wrap.
module seg_display_scanner
    import seg_display_scanner_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = NUM_DIGITS_DEF,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned GUARD_CYCLES = 1
) (
    input logic                  clk,
    input logic                  rst,
    seg_display_scanner_if.slave bus
);

    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned GUARD_W = $clog2(GUARD_CYCLES + 1);
    localparam int unsigned DIG_W   = 4 * NUM_DIGITS;

    logic                  w_step;
    logic                  w_scan_level_unused;
    logic                  w_blink;
    logic                  w_blink_rise_unused;
    logic                  w_wrap;
    logic [3:0]            w_nibble;
    logic                  w_dark;
    logic [NUM_DIGITS-1:0] w_drive_an;
    logic [6:0]            w_drive_seg;
    logic                  w_drive_dp;

    logic [IDX_W-1:0]      r_idx;
    logic [GUARD_W-1:0]    r_guard;
    logic                  r_started;
    logic [DIG_W-1:0]      r_pend_digits, r_act_digits;
    logic [NUM_DIGITS-1:0] r_pend_dp, r_act_dp;
    logic [NUM_DIGITS-1:0] r_pend_blank, r_act_blank;
    logic [NUM_DIGITS-1:0] r_pend_blink, r_act_blink;
    logic                  r_pend_valid;
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;
    logic                  r_dp;

    seg_display_scanner_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scan_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.scan_clk),
        .o_level (w_scan_level_unused),
        .o_rise  (w_step)
    );

    seg_display_scanner_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_blink_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.blink_clk),
        .o_level (w_blink),
        .o_rise  (w_blink_rise_unused)
    );

    assign w_wrap = (r_idx == IDX_W'(NUM_DIGITS - 1));

    always_comb begin
        w_nibble    = r_act_digits[{r_idx, 2'b00} +: 4];
        w_dark      = r_act_blank[r_idx] | (r_act_blink[r_idx] & ~w_blink);
        w_drive_an  = ~(NUM_DIGITS'(1) << r_idx);
        w_drive_seg = w_dark ? SEG_BLANK : hex_to_seg(w_nibble);
        w_drive_dp  = w_dark | ~r_act_dp[r_idx];
    end

    // A load coinciding with the wrap step bypasses pending and commits directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx         <= '0;
            r_guard       <= '0;
            r_started     <= 1'b0;
            r_pend_digits <= '0;
            r_pend_dp     <= '0;
            r_pend_blank  <= '0;
            r_pend_blink  <= '0;
            r_pend_valid  <= 1'b0;
            r_act_digits  <= '0;
            r_act_dp      <= '0;
            r_act_blank   <= '0;
            r_act_blink   <= '0;
            r_an          <= {NUM_DIGITS{AN_OFF}};
            r_seg         <= SEG_BLANK;
            r_dp          <= 1'b1;
        end else begin
            if (bus.load) begin
                r_pend_digits <= bus.digits;
                r_pend_dp     <= bus.dp_in;
                r_pend_blank  <= bus.blank_mask;
                r_pend_blink  <= bus.blink_mask;
                r_pend_valid  <= ~(w_step & w_wrap);
            end
            if (w_step) begin
                r_idx     <= w_wrap ? '0 : r_idx + IDX_W'(1);
                r_guard   <= GUARD_W'(GUARD_CYCLES);
                r_started <= 1'b1;
                r_an      <= {NUM_DIGITS{AN_OFF}};
                r_seg     <= SEG_BLANK;
                r_dp      <= 1'b1;
                if (w_wrap) begin
                    if (bus.load) begin
                        r_act_digits <= bus.digits;
                        r_act_dp     <= bus.dp_in;
                        r_act_blank  <= bus.blank_mask;
                        r_act_blink  <= bus.blink_mask;
                    end else if (r_pend_valid) begin
                        r_act_digits <= r_pend_digits;
                        r_act_dp     <= r_pend_dp;
                        r_act_blank  <= r_pend_blank;
                        r_act_blink  <= r_pend_blink;
                    end
                    if (!bus.load) begin
                        r_pend_valid <= 1'b0;
                    end
                end
            end else if (r_guard != '0) begin
                r_guard <= r_guard - GUARD_W'(1);
                if (r_guard == GUARD_W'(1)) begin
                    r_an  <= w_drive_an;
                    r_seg <= w_drive_seg;
                    r_dp  <= w_drive_dp;
                end
            end else if (r_started) begin
                r_an  <= w_drive_an;
                r_seg <= w_drive_seg;
                r_dp  <= w_drive_dp;
            end
        end
    end

    assign bus.an        = r_an;
    assign bus.seg       = r_seg;
    assign bus.dp_out    = r_dp;
    assign bus.digit_idx = r_idx;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner: directed scenarios plus random
// frames, checked against a frame-level behavioural model of the display.
module tb_seg_display_scanner;

    localparam int unsigned ND        = 4;
    localparam int unsigned SS        = 2;
    localparam int unsigned GC        = 1;
    localparam int unsigned STEP_EDGE = SS + 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seg_display_scanner_if #(.NUM_DIGITS(ND)) bus ();

    seg_display_scanner #(
        .NUM_DIGITS   (ND),
        .SYNC_STAGES  (SS),
        .GUARD_CYCLES (GC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [6:0] seg_table [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int          m_idx;
    bit          m_blink;
    bit          m_pv;
    logic [15:0] m_pend_d, m_act_d;
    logic [3:0]  m_pend_dp, m_pend_bl, m_pend_bk, m_act_dp, m_act_bl, m_act_bk;

    function automatic void model_reset();
        m_idx = 0; m_pv = 0;
        m_pend_d = '0; m_pend_dp = '0; m_pend_bl = '0; m_pend_bk = '0;
        m_act_d  = '0; m_act_dp  = '0; m_act_bl  = '0; m_act_bk  = '0;
    endfunction

    function automatic void model_load(logic [15:0] d, logic [3:0] dp, logic [3:0] bl, logic [3:0] bk);
        m_pend_d = d; m_pend_dp = dp; m_pend_bl = bl; m_pend_bk = bk; m_pv = 1;
    endfunction

    function automatic void model_step(bit ld, logic [15:0] d, logic [3:0] dp, logic [3:0] bl, logic [3:0] bk);
        m_idx = (m_idx + 1) % ND;
        if (ld) model_load(d, dp, bl, bk);
        if (m_idx == 0) begin
            if (m_pv) begin
                m_act_d = m_pend_d; m_act_dp = m_pend_dp; m_act_bl = m_pend_bl; m_act_bk = m_pend_bk;
            end
            m_pv = 0;
        end
    endfunction

    function automatic bit exp_dark(int i);
        return m_act_bl[i] || (m_act_bk[i] && !m_blink);
    endfunction

    function automatic logic [6:0] exp_seg(int i);
        return exp_dark(i) ? 7'h7F : seg_table[m_act_d[4*i +: 4]];
    endfunction

    function automatic logic exp_dp(int i);
        return exp_dark(i) ? 1'b1 : ~m_act_dp[i];
    endfunction

    function automatic logic [3:0] exp_an(int i);
        return ~(4'b0001 << i);
    endfunction

    task automatic do_load(logic [15:0] d, logic [3:0] dp, logic [3:0] bl, logic [3:0] bk);
        @(posedge clk); #1;
        bus.digits = d; bus.dp_in = dp; bus.blank_mask = bl; bus.blink_mask = bk; bus.load = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0;
        model_load(d, dp, bl, bk);
    endtask

    task automatic set_blink(bit v);
        bus.blink_clk = v;
        m_blink = v;
        repeat (SS + 3) @(posedge clk);
        @(negedge clk);
    endtask

    // One scan_clk rise; optional load timed to the step edge, optional reset inside the guard.
    task automatic step_capture(input bit ld, input logic [15:0] d, input logic [3:0] dp,
                                input logic [3:0] bl, input logic [3:0] bk, input bit rst_mid,
                                output int lat, output int gap, output logic [1:0] idx,
                                output logic [3:0] an, output logic [6:0] sg, output logic dpo);
        logic [1:0] start;
        start = bus.digit_idx;
        lat = 0; gap = 0;
        @(posedge clk); #1;
        bus.scan_clk = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            if (ld && n == STEP_EDGE - 1) begin
                #1; bus.digits = d; bus.dp_in = dp; bus.blank_mask = bl; bus.blink_mask = bk; bus.load = 1'b1;
            end
            if (ld && n == STEP_EDGE) begin
                #1; bus.load = 1'b0;
            end
            @(negedge clk);
            if (bus.digit_idx !== start) begin
                lat = n;
                break;
            end
        end
        bus.load = 1'b0;
        if (rst_mid) begin
            #1 rst = 1'b0;
            #1;
        end else begin
            while (bus.an === 4'hF && gap < 20) begin
                gap++;
                @(negedge clk);
            end
        end
        idx = bus.digit_idx; an = bus.an; sg = bus.seg; dpo = bus.dp_out;
        bus.scan_clk = 1'b0;
        repeat (SS + 3) @(posedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.an !== 4'hF) begin errors++; $display("FAIL reset_an got=%b exp=1111", bus.an); end
        checks++; if (bus.seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%h exp=7f", bus.seg); end
        checks++; if (bus.dp_out !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", bus.dp_out); end
        checks++; if (bus.digit_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", bus.digit_idx); end
        @(posedge clk); #1 rst = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.an !== 4'hF) begin errors++; $display("FAIL idle_an got=%b exp=1111", bus.an); end
        checks++; if (bus.seg !== 7'h7F) begin errors++; $display("FAIL idle_seg got=%h exp=7f", bus.seg); end
        checks++; if (bus.digit_idx !== 2'd0) begin errors++; $display("FAIL idle_idx got=%0d exp=0", bus.digit_idx); end
        model_reset();
    endtask

    task automatic test_scan_order();
        int lat, gap; logic [1:0] idx; logic [3:0] an; logic [6:0] sg; logic dpo;
        do_load(16'h1234, 4'h0, 4'h0, 4'h0);
        for (int s = 0; s < 8; s++) begin
            step_capture(0, '0, '0, '0, '0, 0, lat, gap, idx, an, sg, dpo);
            model_step(0, '0, '0, '0, '0);
            checks++; if (lat != STEP_EDGE) begin errors++; $display("FAIL order_latency s=%0d got=%0d exp=%0d", s, lat, STEP_EDGE); end
            checks++; if (gap != GC) begin errors++; $display("FAIL order_guard s=%0d got=%0d exp=%0d", s, gap, GC); end
            checks++; if (idx !== 2'(m_idx)) begin errors++; $display("FAIL order_idx s=%0d got=%0d exp=%0d", s, idx, m_idx); end
            checks++; if (an !== exp_an(m_idx)) begin errors++; $display("FAIL order_an s=%0d got=%b exp=%b", s, an, exp_an(m_idx)); end
            checks++; if (sg !== exp_seg(m_idx)) begin errors++; $display("FAIL order_seg s=%0d got=%h exp=%h", s, sg, exp_seg(m_idx)); end
            checks++; if (dpo !== exp_dp(m_idx)) begin errors++; $display("FAIL order_dp s=%0d got=%b exp=%b", s, dpo, exp_dp(m_idx)); end
        end
    endtask

    task automatic test_mid_frame_load();
        int lat, gap; logic [1:0] idx; logic [3:0] an; logic [6:0] sg; logic dpo;
        for (int s = 0; s < 6; s++) begin
            if (s == 2) do_load(16'hAAAA, 4'h0, 4'h0, 4'h0);
            step_capture(0, '0, '0, '0, '0, 0, lat, gap, idx, an, sg, dpo);
            model_step(0, '0, '0, '0, '0);
            checks++; if (idx !== 2'(m_idx)) begin errors++; $display("FAIL midload_idx s=%0d got=%0d exp=%0d", s, idx, m_idx); end
            checks++; if (an !== exp_an(m_idx)) begin errors++; $display("FAIL midload_an s=%0d got=%b exp=%b", s, an, exp_an(m_idx)); end
            checks++; if (sg !== exp_seg(m_idx)) begin errors++; $display("FAIL midload_seg s=%0d got=%h exp=%h", s, sg, exp_seg(m_idx)); end
        end
    endtask

    task automatic test_load_at_wrap();
        int lat, gap; logic [1:0] idx; logic [3:0] an; logic [6:0] sg; logic dpo;
        do_load(16'h1111, 4'h0, 4'h0, 4'h0);
        for (int s = 0; s < 4; s++) begin
            step_capture(s == 0, 16'h8888, 4'h0, 4'h0, 4'h0, 0, lat, gap, idx, an, sg, dpo);
            model_step(s == 0, 16'h8888, 4'h0, 4'h0, 4'h0);
            checks++; if (idx !== 2'(m_idx)) begin errors++; $display("FAIL wrapload_idx s=%0d got=%0d exp=%0d", s, idx, m_idx); end
            checks++; if (sg !== exp_seg(m_idx)) begin errors++; $display("FAIL wrapload_seg s=%0d got=%h exp=%h", s, sg, exp_seg(m_idx)); end
        end
    endtask

    task automatic test_blank_blink();
        int lat, gap; logic [1:0] idx; logic [3:0] an; logic [6:0] sg; logic dpo;
        bit sched [6] = '{1, 1, 1, 1, 0, 0};
        do_load(16'h5678, 4'b0100, 4'b0001, 4'b0010);
        for (int s = 0; s < 6; s++) begin
            set_blink(sched[s]);
            step_capture(0, '0, '0, '0, '0, 0, lat, gap, idx, an, sg, dpo);
            model_step(0, '0, '0, '0, '0);
            checks++; if (an !== exp_an(m_idx)) begin errors++; $display("FAIL blink_an s=%0d got=%b exp=%b", s, an, exp_an(m_idx)); end
            checks++; if (sg !== exp_seg(m_idx)) begin errors++; $display("FAIL blink_seg s=%0d got=%h exp=%h", s, sg, exp_seg(m_idx)); end
            checks++; if (dpo !== exp_dp(m_idx)) begin errors++; $display("FAIL blink_dp s=%0d got=%b exp=%b", s, dpo, exp_dp(m_idx)); end
            if (m_idx == 1 && m_blink) begin
                for (int t = 0; t < 2; t++) begin
                    set_blink(t == 1);
                    checks++; if (bus.seg !== exp_seg(1)) begin errors++; $display("FAIL blink_toggle t=%0d got=%h exp=%h", t, bus.seg, exp_seg(1)); end
                    checks++; if (bus.an !== exp_an(1)) begin errors++; $display("FAIL blink_toggle_an t=%0d got=%b exp=%b", t, bus.an, exp_an(1)); end
                end
            end
        end
    endtask

    task automatic test_random();
        int lat, gap; logic [1:0] idx; logic [3:0] an; logic [6:0] sg; logic dpo;
        logic [15:0] d; logic [3:0] dp, bl, bk; bit ld;
        for (int s = 0; s < 16; s++) begin
            if ($urandom_range(0, 2) == 0)
                do_load(16'($urandom), 4'($urandom), 4'($urandom_range(0, 3)), 4'($urandom));
            set_blink(1'($urandom_range(0, 1)));
            ld = ($urandom_range(0, 3) == 0);
            d = 16'($urandom); dp = 4'($urandom); bl = 4'($urandom_range(0, 3)); bk = 4'($urandom);
            step_capture(ld, d, dp, bl, bk, 0, lat, gap, idx, an, sg, dpo);
            model_step(ld, d, dp, bl, bk);
            checks++; if (gap != GC) begin errors++; $display("FAIL rand_guard s=%0d got=%0d exp=%0d", s, gap, GC); end
            checks++; if (idx !== 2'(m_idx)) begin errors++; $display("FAIL rand_idx s=%0d got=%0d exp=%0d", s, idx, m_idx); end
            checks++; if (an !== exp_an(m_idx)) begin errors++; $display("FAIL rand_an s=%0d got=%b exp=%b", s, an, exp_an(m_idx)); end
            checks++; if (sg !== exp_seg(m_idx)) begin errors++; $display("FAIL rand_seg s=%0d got=%h exp=%h", s, sg, exp_seg(m_idx)); end
            checks++; if (dpo !== exp_dp(m_idx)) begin errors++; $display("FAIL rand_dp s=%0d got=%b exp=%b", s, dpo, exp_dp(m_idx)); end
        end
    endtask

    task automatic test_reset_mid_guard();
        int lat, gap; logic [1:0] idx; logic [3:0] an; logic [6:0] sg; logic dpo;
        for (int s = 0; s < 4 && m_idx != 2; s++) begin
            step_capture(0, '0, '0, '0, '0, 0, lat, gap, idx, an, sg, dpo);
            model_step(0, '0, '0, '0, '0);
        end
        do_load(16'h9999, 4'hF, 4'h0, 4'h0);
        step_capture(0, '0, '0, '0, '0, 1, lat, gap, idx, an, sg, dpo);
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL rstmid_an got=%b exp=1111", an); end
        checks++; if (sg !== 7'h7F) begin errors++; $display("FAIL rstmid_seg got=%h exp=7f", sg); end
        checks++; if (dpo !== 1'b1) begin errors++; $display("FAIL rstmid_dp got=%b exp=1", dpo); end
        checks++; if (idx !== 2'd0) begin errors++; $display("FAIL rstmid_idx got=%0d exp=0", idx); end
        model_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.an !== 4'hF) begin errors++; $display("FAIL rstmid_idle_an got=%b exp=1111", bus.an); end
        step_capture(0, '0, '0, '0, '0, 0, lat, gap, idx, an, sg, dpo);
        model_step(0, '0, '0, '0, '0);
        checks++; if (idx !== 2'(m_idx)) begin errors++; $display("FAIL rstmid_step_idx got=%0d exp=%0d", idx, m_idx); end
        checks++; if (an !== exp_an(m_idx)) begin errors++; $display("FAIL rstmid_step_an got=%b exp=%b", an, exp_an(m_idx)); end
        checks++; if (sg !== exp_seg(m_idx)) begin errors++; $display("FAIL rstmid_step_seg got=%h exp=%h", sg, exp_seg(m_idx)); end
        checks++; if (dpo !== exp_dp(m_idx)) begin errors++; $display("FAIL rstmid_step_dp got=%b exp=%b", dpo, exp_dp(m_idx)); end
    endtask

    initial begin
        bus.scan_clk = 1'b0; bus.blink_clk = 1'b0; bus.load = 1'b0;
        bus.digits = '0; bus.dp_in = '0; bus.blank_mask = '0; bus.blink_mask = '0;
        m_blink = 0;
        model_reset();
        test_reset();
        test_scan_order();
        test_mid_frame_load();
        test_load_at_wrap();
        test_blank_blink();
        test_random();
        test_reset_mid_guard();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
